// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single register-file write port between two requesters (ALU
// writeback and memory load). After reset it first runs a clear sequence
// that writes zero to registers 1..31, one per cycle. It then arbitrates
// requests round-robin, issuing at most one write per cycle.
//
// Ports
//   clock            : system clock, all state changes on the rising edge
//   ctrl_reset       : synchronous active-high reset
//   req0 / req1      : write requests (0 = ALU writeback, 1 = memory load)
//   wreg0 / wreg1    : destination register index, held while req is high
//   wdata0 / wdata1  : write data, held while req is high
//   ack0 / ack1      : one-cycle pulse in the cycle the granted write is issued
//   ctrl_writeEnable : register-file write strobe
//   ctrl_writeReg    : register-file write index
//   data_writeReg    : register-file write data
//   busy             : high while the clear sequence runs (requests ignored)
// ---------------------------------------------------------------------------
module regfile_write_arbiter (
   input  logic        clock,
   input  logic        ctrl_reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [4:0]  wreg0,
   input  logic [4:0]  wreg1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] data_writeReg,
   output logic        busy
);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;        // next register to clear
   logic        last_q, last_d;      // last granted requester (1 = requester 1)
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        we_q, we_d;
   logic [4:0]  wreg_q, wreg_d;
   logic [31:0] wdata_q, wdata_d;
   logic        busy_q, busy_d;

   logic        elig0, elig1;
   logic        grant_any, grant_sel1;

   // A requester still showing its request in its own ack cycle is holding the
   // already-written request, so it is not eligible again in that cycle.
   assign elig0 = req0 & ~ack0_q;
   assign elig1 = req1 & ~ack1_q;
   assign grant_any = elig0 | elig1;
   // Requester 1 wins when it is alone, or on a tie when requester 0 went last.
   assign grant_sel1 = elig1 & (~elig0 | ~last_q);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      we_d    = 1'b0;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      busy_d  = busy_q;

      unique case (state_q)
         ST_CLEAR: begin
            we_d    = 1'b1;
            wreg_d  = cnt_q;
            wdata_d = 32'd0;
            cnt_d   = cnt_q + 5'd1;
            busy_d  = 1'b1;
            // The edge that issues the write to register 31 leaves CLEAR, so
            // busy is already low in the cycle that write is visible.
            if (cnt_q == 5'd31) begin
               state_d = ST_RUN;
               busy_d  = 1'b0;
            end
         end
         ST_RUN: begin
            busy_d = 1'b0;
            if (grant_any) begin
               ack0_d  = ~grant_sel1;
               ack1_d  = grant_sel1;
               wreg_d  = grant_sel1 ? wreg1  : wreg0;
               wdata_d = grant_sel1 ? wdata1 : wdata0;
               // Register 0 is hardwired to zero: acknowledge but do not write.
               we_d    = (wreg_d != 5'd0);
               last_d  = grant_sel1;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         state_q <= ST_CLEAR;
         cnt_q   <= 5'd1;
         last_q  <= 1'b1;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         we_q    <= 1'b0;
         wreg_q  <= 5'd0;
         wdata_q <= 32'd0;
         busy_q  <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         we_q    <= we_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
      end
   end

   assign ack0             = ack0_q;
   assign ack1             = ack1_q;
   assign ctrl_writeEnable = we_q;
   assign ctrl_writeReg    = wreg_q;
   assign data_writeReg    = wdata_q;
   assign busy             = busy_q;

endmodule
